// File: rtl/if_fetch_if.sv
// Instruction SRAM request/response bus between the fetch stage and memory.
// master: fetch stage (issues requests, consumes responses).
// slave:  instruction memory (accepts requests, returns instruction words).
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_addr_ok,
    input  inst_data_ok,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_addr_ok,
    output inst_data_ok,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, runs the single-outstanding
// request/response handshake to instruction SRAM and presents the fetched
// PC/instruction/exception flags to the IF/ID register. A delivered PC of 0
// is a bubble.
//
// Optional feature: define IF_ADEL_EN to trap misaligned fetch addresses.
// Such a PC is never sent to memory; it is delivered at once with if_inst=0
// and bit ADEL_BIT of if_exceptions set. Without the macro the low two PC
// bits are simply masked off the fetch address.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          ADEL_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic         flush,
  input  logic [31:0]  flush_pc,
  input  logic         branch_flag,
  input  logic [31:0]  branch_target,
  if_fetch_if.master   bus,
  output logic [31:0]  if_pc,
  output logic [31:0]  if_inst,
  output logic [31:0]  if_exceptions,
  output logic         stallreq_if
);

  localparam logic [31:0] ADEL_MASK = 32'd1 << ADEL_BIT;

  // S_REQ:  request the current pc
  // S_WAIT: request accepted, waiting for data
  // S_HOLD: data received but IF stalled, replay it from the buffer
  // S_DROP: a flush orphaned an accepted request, swallow its response
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] buffer;

  logic        req;
  logic [31:0] addr;
  logic        delivering;
  logic        busy;
  logic [31:0] out_inst;
  logic [31:0] out_exc;
  logic        deliver_out;
  logic        advance;
  logic        accepted;
  logic        orphaned;
  logic [31:0] next_pc;

  // Only stall[1] concerns this stage; the other stall bits belong to later stages.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

`ifndef IF_ADEL_EN
  logic [31:0] unused_adel_mask;
  assign unused_adel_mask = ADEL_MASK;
`endif

  // Per-state bus request, delivery and stall request; everything is forced quiet during reset.
  always_comb begin
    req        = 1'b0;
    addr       = '0;
    delivering = 1'b0;
    busy       = 1'b0;
    out_inst   = '0;
    out_exc    = '0;
    case (state)
      S_REQ: begin
`ifdef IF_ADEL_EN
        if (pc[1:0] != 2'b00) begin
          delivering = 1'b1;
          out_exc    = ADEL_MASK;
        end else begin
          req  = 1'b1;
          addr = pc;
          busy = 1'b1;
        end
`else
        req  = 1'b1;
        addr = {pc[31:2], 2'b00};
        busy = 1'b1;
`endif
      end
      S_WAIT: begin
        if (bus.inst_data_ok) begin
          delivering = 1'b1;
          out_inst   = bus.inst_rdata;
        end else begin
          busy = 1'b1;
        end
      end
      S_HOLD: begin
        delivering = 1'b1;
        out_inst   = buffer;
      end
      S_DROP: begin
        busy = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
    if (!rst) begin
      req        = 1'b0;
      addr       = '0;
      delivering = 1'b0;
      busy       = 1'b0;
    end
  end

  // A flush turns the delivery into a bubble and blocks any PC advance.
  assign deliver_out = delivering && !flush;
  assign advance     = delivering && !stall[1] && !flush;
  assign accepted    = req && bus.inst_addr_ok;
  assign next_pc     = redir_valid ? redir_target : pc + 32'd4;

  // An accepted request without its response yet must be drained after a flush.
  assign orphaned = accepted ||
                    ((state == S_WAIT || state == S_DROP) && !bus.inst_data_ok);

  assign bus.inst_req  = req;
  assign bus.inst_addr = addr;
  assign if_pc         = deliver_out ? pc       : '0;
  assign if_inst       = deliver_out ? out_inst : '0;
  assign if_exceptions = deliver_out ? out_exc  : '0;
  assign stallreq_if   = busy;

  // PC, pending redirect, response buffer and fetch state machine.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_REQ;
      pc           <= RESET_PC;
      redir_valid  <= 1'b0;
      redir_target <= '0;
      buffer       <= '0;
    end else if (flush) begin
      pc          <= flush_pc;
      redir_valid <= 1'b0;
      state       <= orphaned ? S_DROP : S_REQ;
    end else begin
      if (advance) begin
        pc          <= next_pc;
        redir_valid <= 1'b0;
      end
      // A branch seen together with an advance still lets the delay slot
      // (pc+4) go first; the target is used on the following advance.
      if (branch_flag) begin
        redir_valid  <= 1'b1;
        redir_target <= branch_target;
      end
      case (state)
        S_REQ: begin
          if (accepted) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.inst_data_ok) begin
            if (advance) begin
              state <= S_REQ;
            end else begin
              buffer <= bus.inst_rdata;
              state  <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (advance) begin
            state <= S_REQ;
          end
        end
        S_DROP: begin
          if (bus.inst_data_ok) begin
            state <= S_REQ;
          end
        end
        default: begin
          state <= S_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Testbench for if_fetch: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of the fetch stream and a
// single-slot SRAM model with random latency.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] flush_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic [31:0] if_exceptions;
  logic        stallreq_if;

  if_fetch_if bus ();

  if_fetch #(.RESET_PC(RESET_PC), .ADEL_BIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .bus           (bus),
    .if_pc         (if_pc),
    .if_inst       (if_inst),
    .if_exceptions (if_exceptions),
    .stallreq_if   (stallreq_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // SRAM model: one outstanding slot, response after s_delay idle cycles
  logic        s_busy = 1'b0;
  logic [31:0] s_addr = '0;
  int          s_delay = 0;

  // fetch-stream model
  logic [31:0] m_pc = RESET_PC;
  logic        m_redir = 1'b0;
  logic [31:0] m_target = '0;
  logic        m_fetched = 1'b0;
  logic [31:0] m_held = '0;
  logic        m_cur_out = 1'b0;
  logic        m_stale_out = 1'b0;

  // values captured for the current cycle
  logic        c_flush, c_branch, c_stall1, c_aok, c_dok, c_req_exp, c_deliver;
  logic [31:0] c_fpc, c_bt, c_rdata, c_addr;
  int          c_lat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h9BC1_0001;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let it settle and compare against the model.
  task automatic applyStimulus(input logic [5:0] st, input logic br, input logic [31:0] bt,
                               input logic fl, input logic [31:0] fpc,
                               input logic aok_allow, input int lat);
    logic mis;
    logic [31:0] exp_inst, exp_exc;
`ifdef IF_ADEL_EN
    mis = (m_pc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    c_dok     = s_busy && (s_delay == 0);
    c_rdata   = c_dok ? mem_word(s_addr) : $urandom;
    c_req_exp = !m_fetched && !m_cur_out && !m_stale_out && !mis;
    c_aok     = aok_allow && !s_busy && bus.inst_req;
    c_addr    = bus.inst_addr;
    c_lat     = lat;
    c_flush   = fl;
    c_fpc     = fpc;
    c_branch  = br;
    c_bt      = bt;
    c_stall1  = st[1];
    stall             = st;
    branch_flag       = br;
    branch_target     = bt;
    flush             = fl;
    flush_pc          = fpc;
    bus.inst_addr_ok  = c_aok;
    bus.inst_data_ok  = c_dok;
    bus.inst_rdata    = c_rdata;
    #2;
    c_deliver = !fl && (mis || m_fetched || (m_cur_out && c_dok));
    exp_inst  = mis ? 32'h0 : (m_fetched ? m_held : c_rdata);
    exp_exc   = mis ? 32'h10 : 32'h0;
    checkOutput("inst_req", {31'b0, bus.inst_req}, {31'b0, c_req_exp});
    if (c_req_exp) checkOutput("inst_addr", bus.inst_addr, {m_pc[31:2], 2'b00});
    checkOutput("if_pc", if_pc, c_deliver ? m_pc : 32'h0);
    checkOutput("if_inst", if_inst, c_deliver ? exp_inst : 32'h0);
    checkOutput("if_exceptions", if_exceptions, c_deliver ? exp_exc : 32'h0);
    if (!fl) checkOutput("stallreq_if", {31'b0, stallreq_if}, {31'b0, !c_deliver});
  endtask

  // Clock edge: advance the SRAM model and the fetch-stream model.
  task automatic stepCycle();
    logic accepted, adv;
    @(posedge clk);
    if (c_dok) s_busy = 1'b0;
    else if (s_busy) s_delay--;
    if (c_aok) begin
      s_busy  = 1'b1;
      s_addr  = c_addr;
      s_delay = c_lat;
    end
    accepted = c_aok && c_req_exp;
    if (c_flush) begin
      m_stale_out = accepted || (m_cur_out && !c_dok) || (m_stale_out && !c_dok);
      m_pc        = c_fpc;
      m_redir     = 1'b0;
      m_fetched   = 1'b0;
      m_cur_out   = 1'b0;
    end else begin
      adv = c_deliver && !c_stall1;
      if (m_stale_out && c_dok) m_stale_out = 1'b0;
      if (m_cur_out && c_dok) begin
        m_cur_out = 1'b0;
        if (!adv) begin
          m_fetched = 1'b1;
          m_held    = c_rdata;
        end
      end
      if (accepted) m_cur_out = 1'b1;
      if (adv) begin
        m_pc      = m_redir ? m_target : m_pc + 32'd4;
        m_redir   = 1'b0;
        m_fetched = 1'b0;
      end
      if (c_branch) begin
        m_redir  = 1'b1;
        m_target = c_bt;
      end
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    stepCycle();
  endtask

  // Hold reset for n cycles while the SRAM keeps answering anything in flight.
  task automatic doReset(input int n);
    rst = 1'b0;
    stall = '0; flush = 1'b0; flush_pc = '0; branch_flag = 1'b0; branch_target = '0;
    bus.inst_addr_ok = 1'b0;
    for (int i = 0; i < n; i++) begin
      c_dok = s_busy && (s_delay == 0);
      bus.inst_data_ok = c_dok;
      bus.inst_rdata   = c_dok ? mem_word(s_addr) : $urandom;
      #1;
      checkOutput("rst_inst_req", {31'b0, bus.inst_req}, 32'h0);
      checkOutput("rst_if_pc", if_pc, 32'h0);
      checkOutput("rst_if_inst", if_inst, 32'h0);
      checkOutput("rst_if_exc", if_exceptions, 32'h0);
      checkOutput("rst_stallreq", {31'b0, stallreq_if}, 32'h0);
      @(posedge clk);
      if (c_dok) s_busy = 1'b0;
      else if (s_busy) s_delay--;
      #1;
    end
    m_pc = RESET_PC; m_redir = 1'b0; m_fetched = 1'b0;
    m_cur_out = 1'b0; m_stale_out = 1'b0;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    logic [5:0]  st;
    logic        br, fl;
    logic [31:0] bt, fpc;

    bus.inst_addr_ok = 1'b0;
    bus.inst_data_ok = 1'b0;
    bus.inst_rdata   = '0;
    doReset(2);

    // basic fetch from the reset vector
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    checkOutput("t1_addr", bus.inst_addr, 32'hBFC0_0000);
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    checkOutput("t1_if_pc", if_pc, 32'hBFC0_0000);
    checkOutput("t1_if_inst", if_inst, 32'h2401_0001);
    stepCycle();

    // stall on delivery: three cycles held, then advance
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    checkOutput("t1_next_addr", bus.inst_addr, 32'hBFC0_0004);
    stepCycle();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(6'b000010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
      checkOutput("t2_hold_inst", if_inst, mem_word(32'hBFC0_0004));
      checkOutput("t2_hold_stallreq", {31'b0, stallreq_if}, 32'h0);
      stepCycle();
    end
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    checkOutput("t2_release_pc", if_pc, 32'hBFC0_0004);
    stepCycle();

    // branch seen while the delay slot is in flight
    applyStimulus(6'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0, 1'b1, 0);
    checkOutput("t3_slot_addr", bus.inst_addr, 32'hBFC0_0008);
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    checkOutput("t3_slot_pc", if_pc, 32'hBFC0_0008);
    stepCycle();

    // flush while waiting: stale response must be swallowed
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 2);
    checkOutput("t3_target_addr", bus.inst_addr, 32'hBFC0_0100);
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380, 1'b0, 0);
    checkOutput("t4_flush_bubble", if_pc, 32'h0);
    stepCycle();
    idle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
    checkOutput("t4_stale_inst", if_inst, 32'h0);
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    checkOutput("t4_flush_addr", bus.inst_addr, 32'hBFC0_0380);
    stepCycle();
    idle();
    idle();

    // misaligned flush target
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0002, 1'b0, 0);
    stepCycle();
    applyStimulus(6'b000010, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0);
`ifdef IF_ADEL_EN
    checkOutput("t5_req", {31'b0, bus.inst_req}, 32'h0);
    checkOutput("t5_if_pc", if_pc, 32'hBFC0_0002);
    checkOutput("t5_if_inst", if_inst, 32'h0);
    checkOutput("t5_exc", if_exceptions, 32'h10);
`else
    checkOutput("t5_addr", bus.inst_addr, 32'hBFC0_0000);
    checkOutput("t5_exc", if_exceptions, 32'h0);
`endif
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b1, 32'hBFC0_0400, 1'b0, 0);
    stepCycle();

    // reset in the middle of a fetch; stale response afterwards is ignored
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 3);
    stepCycle();
    idle();
    doReset(1);
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    checkOutput("t6_req", {31'b0, bus.inst_req}, 32'h1);
    checkOutput("t6_addr", bus.inst_addr, RESET_PC);
    stepCycle();
    applyStimulus(6'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0);
    checkOutput("t6_stale_pc", if_pc, 32'h0);
    stepCycle();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) begin
        doReset(1 + $urandom_range(0, 1));
      end else begin
        st = 6'($urandom);
        st[1] = ($urandom_range(0, 9) < 3);
        br = ($urandom_range(0, 9) == 0);
        bt = 32'hBFC0_0000 | ($urandom & 32'h000F_FFFC);
        if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom_range(1, 3));
        fl = ($urandom_range(0, 24) == 0);
        fpc = 32'hBFC0_0000 | ($urandom & 32'h000F_FFFC);
        if ($urandom_range(0, 7) == 0) fpc[1:0] = 2'($urandom_range(1, 3));
        applyStimulus(st, br, bt, fl, fpc, ($urandom_range(0, 9) < 6), $urandom_range(0, 3));
        stepCycle();
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
